// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache.
// Hits are answered from the local arrays one cycle after the request. A miss
// issues a single word fetch to the memory controller, fills the line and
// forwards the word. A pipeline clear during a miss suppresses delivery but
// lets the memory transaction finish and still fills the line.
module icache #(
  parameter int INDEX_WIDTH = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic        if_to_ic_valid,
  input  logic [31:0] if_to_ic_pc,
  output logic        ic_to_if_ready,
  output logic [31:0] ic_to_if_inst,
  output logic        ic_to_mc_ready,
  output logic [31:0] ic_to_mc_pc,
  input  logic        mc_to_ic_ready,
  input  logic [31:0] mc_dout
);

  localparam int LINES     = 1 << INDEX_WIDTH;
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MISS = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic                 drop;
  logic [LINES-1:0]     valid;
  logic [TAG_WIDTH-1:0] tag_mem  [LINES];
  logic [31:0]          data_mem [LINES];

  logic [INDEX_WIDTH-1:0] req_index;
  logic [TAG_WIDTH-1:0]   req_tag;
  logic [INDEX_WIDTH-1:0] fill_index;
  logic [TAG_WIDTH-1:0]   fill_tag;
  logic                   hit;
  logic                   fill_en;
  logic                   deliver;
  logic                   unused_pc_bits;

  // Address split for the incoming request and for the outstanding miss.
  assign req_index  = if_to_ic_pc[INDEX_WIDTH+1:2];
  assign req_tag    = if_to_ic_pc[31:INDEX_WIDTH+2];
  assign fill_index = ic_to_mc_pc[INDEX_WIDTH+1:2];
  assign fill_tag   = ic_to_mc_pc[31:INDEX_WIDTH+2];

  // Byte-offset bits are always zero for word-aligned fetches.
  assign unused_pc_bits = ^{if_to_ic_pc[1:0], ic_to_mc_pc[1:0]};

  assign hit = valid[req_index] && (tag_mem[req_index] == req_tag);

  // The fill happens on the completion pulse, but only in an enabled cycle
  // so that a pulse seen while frozen is left for a later cycle.
  assign fill_en = rdy_in && (state == MISS) && mc_to_ic_ready;
  assign deliver = fill_en && !drop && !clr_in;

  // The request drops combinationally in the completion cycle, because the
  // controller re-samples it in that same cycle and would otherwise start a
  // second fetch.
  assign ic_to_mc_ready = (state == MISS) && !mc_to_ic_ready;

  // Next-state selection for the IDLE / MISS / RESP sequence.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!clr_in && if_to_ic_valid) begin
          state_next = hit ? RESP : MISS;
        end
      end
      MISS: begin
        if (mc_to_ic_ready) begin
          state_next = deliver ? RESP : IDLE;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control registers and fetch-unit / controller facing outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state          <= IDLE;
      drop           <= 1'b0;
      ic_to_if_ready <= 1'b0;
      ic_to_if_inst  <= 32'h0;
      ic_to_mc_pc    <= 32'h0;
    end else if (rdy_in) begin
      state <= state_next;
      case (state)
        IDLE: begin
          ic_to_if_ready <= 1'b0;
          if (!clr_in && if_to_ic_valid) begin
            if (hit) begin
              ic_to_if_inst  <= data_mem[req_index];
              ic_to_if_ready <= 1'b1;
            end else begin
              ic_to_mc_pc <= if_to_ic_pc;
              drop        <= 1'b0;
            end
          end
        end
        MISS: begin
          if (mc_to_ic_ready) begin
            if (deliver) begin
              ic_to_if_inst  <= mc_dout;
              ic_to_if_ready <= 1'b1;
            end
          end else if (clr_in) begin
            drop <= 1'b1;
          end
        end
        RESP: begin
          ic_to_if_ready <= 1'b0;
        end
        default: begin
          ic_to_if_ready <= 1'b0;
        end
      endcase
    end
  end

  // Line valid bits; cleared only by reset, never by a pipeline clear.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[fill_index] <= 1'b1;
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk_in) begin
    if (fill_en) begin
      tag_mem[fill_index]  <= fill_tag;
      data_mem[fill_index] <= mc_dout;
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb_icache: table-driven fetch vectors plus hand-written stall, clear and
// reset sequences. A small memory controller model answers misses, and a
// scoreboard queue holds the instruction each delivered response must carry.
module tb_icache;

  logic        clk_in;
  logic        rst_in;
  logic        rdy_in;
  logic        clr_in;
  logic        if_to_ic_valid;
  logic [31:0] if_to_ic_pc;
  logic        ic_to_if_ready;
  logic [31:0] ic_to_if_inst;
  logic        ic_to_mc_ready;
  logic [31:0] ic_to_mc_pc;
  logic        mc_to_ic_ready;
  logic [31:0] mc_dout;

  typedef struct {
    logic [31:0] pc;
    int          clr_cycle;
    bit          exp_miss;
    bit          exp_resp;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[15];

  int checks = 0;
  int errors = 0;
  int fetch_count = 0;
  int resp_count = 0;

  bit          mc_busy = 0;
  int          mc_cnt = 0;
  int          mc_extra = 0;
  logic [31:0] mc_addr = 32'h0;

  logic        s_rst, s_rdy, s_req, s_ack;
  logic [31:0] s_pc;
  logic        prev_en_ready = 1'b0;

  icache #(.INDEX_WIDTH(8)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .clr_in        (clr_in),
    .if_to_ic_valid(if_to_ic_valid),
    .if_to_ic_pc   (if_to_ic_pc),
    .ic_to_if_ready(ic_to_if_ready),
    .ic_to_if_inst (ic_to_if_inst),
    .ic_to_mc_ready(ic_to_mc_ready),
    .ic_to_mc_pc   (ic_to_mc_pc),
    .mc_to_ic_ready(mc_to_ic_ready),
    .mc_dout       (mc_dout)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return 32'h0040_0093;
    return {a[15:0], 16'h0013} ^ 32'h1234_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // One clock cycle: observe outputs at the falling edge, then advance the
  // memory controller model just after the rising edge.
  task automatic step();
    exp_t e;
    @(negedge clk_in);
    s_rst = rst_in;
    s_rdy = rdy_in;
    s_req = ic_to_mc_ready;
    s_pc  = ic_to_mc_pc;
    s_ack = mc_to_ic_ready;
    if (!rst_in) begin
      if (mc_to_ic_ready) check("mc_req_low_in_ack", {31'b0, ic_to_mc_ready}, 32'h0);
      if (mc_busy && ic_to_mc_ready) check("mc_pc_stable", ic_to_mc_pc, mc_addr);
      if (rdy_in) begin
        if (ic_to_if_ready) begin
          check("resp_pulse_width", {31'b0, prev_en_ready}, 32'h0);
          resp_count++;
          if (sb.size() == 0) begin
            check("unexpected_resp", ic_to_if_inst, 32'hDEAD_BEEF ^ ic_to_if_inst);
          end else begin
            e = sb.pop_front();
            check("resp_inst", ic_to_if_inst, e.inst);
          end
        end
        prev_en_ready = ic_to_if_ready;
      end
    end else begin
      prev_en_ready = 1'b0;
    end
    @(posedge clk_in);
    #1;
    if (s_rst) begin
      mc_busy = 0;
      mc_cnt = 0;
      mc_to_ic_ready = 1'b0;
      mc_dout = 32'h0;
    end else if (s_rdy) begin
      if (s_ack) begin
        mc_to_ic_ready = 1'b0;
        mc_dout = 32'h0;
        mc_busy = 0;
      end else if (mc_busy) begin
        mc_cnt--;
        if (mc_cnt == 0) begin
          mc_to_ic_ready = 1'b1;
          mc_dout = mem_word(mc_addr);
        end
      end
      if (!mc_busy && s_req) begin
        mc_busy = 1;
        mc_addr = s_pc;
        mc_cnt = 4 + mc_extra;
        fetch_count++;
      end
    end
  endtask

  // One fetch: hold the request until served (or flushed), then check
  // latency, fetch count and whether a response was delivered.
  task automatic run_vec(input vec_t v);
    int  n;
    int  f0;
    int  r0;
    bit  done;
    exp_t e;
    f0 = fetch_count;
    r0 = resp_count;
    if (v.exp_resp) begin
      e.pc = v.pc;
      e.inst = mem_word(v.pc);
      sb.push_back(e);
    end
    if_to_ic_pc = v.pc;
    if_to_ic_valid = 1'b1;
    clr_in = (v.clr_cycle == 0);
    n = 0;
    done = 0;
    while (!done && n < 40) begin
      step();
      n++;
      clr_in = (n == v.clr_cycle);
      if (v.clr_cycle >= 0 && n >= v.clr_cycle) if_to_ic_valid = 1'b0;
      if (v.exp_miss && n == 2) begin
        check("miss_req", {31'b0, ic_to_mc_ready}, 32'h1);
        check("miss_pc", ic_to_mc_pc, v.pc);
      end
      if (v.exp_resp && resp_count != r0) done = 1;
      if (!v.exp_resp && n == 12) done = 1;
    end
    if_to_ic_valid = 1'b0;
    clr_in = 1'b0;
    if (v.exp_resp) check("latency", 32'(n), v.exp_miss ? 32'(8 + mc_extra) : 32'd2);
    else check("no_resp", 32'(resp_count - r0), 32'h0);
    check("fetches", 32'(fetch_count - f0), {31'b0, v.exp_miss});
    step();
  endtask

  initial begin
    int   r0;
    int   f0;
    int   n;
    exp_t e;

    vecs[0]  = '{32'h0000_0004, -1, 1'b1, 1'b1};
    vecs[1]  = '{32'h0000_0004, -1, 1'b0, 1'b1};
    vecs[2]  = '{32'h0000_0404, -1, 1'b1, 1'b1};
    vecs[3]  = '{32'h0000_0004, -1, 1'b1, 1'b1};
    vecs[4]  = '{32'h0000_0404, -1, 1'b1, 1'b1};
    vecs[5]  = '{32'h0000_0008,  3, 1'b1, 1'b0};
    vecs[6]  = '{32'h0000_0008, -1, 1'b0, 1'b1};
    vecs[7]  = '{32'h0000_000C,  6, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_000C, -1, 1'b0, 1'b1};
    vecs[9]  = '{32'h0000_0010,  0, 1'b0, 1'b0};
    vecs[10] = '{32'h0000_0010, -1, 1'b1, 1'b1};
    vecs[11] = '{32'hFFFF_FFFC, -1, 1'b1, 1'b1};
    vecs[12] = '{32'hFFFF_FFFC, -1, 1'b0, 1'b1};
    vecs[13] = '{32'h0000_03FC, -1, 1'b1, 1'b1};
    vecs[14] = '{32'h0000_0010,  1, 1'b0, 1'b1};

    rst_in = 1'b1;
    rdy_in = 1'b1;
    clr_in = 1'b0;
    if_to_ic_valid = 1'b0;
    if_to_ic_pc = 32'h0;
    mc_to_ic_ready = 1'b0;
    mc_dout = 32'h0;
    #3;
    check("reset_if_ready", {31'b0, ic_to_if_ready}, 32'h0);
    check("reset_if_inst", ic_to_if_inst, 32'h0);
    check("reset_mc_ready", {31'b0, ic_to_mc_ready}, 32'h0);
    check("reset_mc_pc", ic_to_mc_pc, 32'h0);
    step();
    step();
    rst_in = 1'b0;
    step();

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Freeze during RESP: the pulse is held while disabled and still counts once.
    r0 = resp_count;
    e.pc = 32'h10;
    e.inst = mem_word(32'h10);
    sb.push_back(e);
    if_to_ic_pc = 32'h10;
    if_to_ic_valid = 1'b1;
    step();
    rdy_in = 1'b0;
    if_to_ic_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_resp_ready", {31'b0, ic_to_if_ready}, 32'h1);
      check("stall_resp_inst", ic_to_if_inst, mem_word(32'h10));
    end
    rdy_in = 1'b1;
    step();
    check("stall_resp_drop", {31'b0, ic_to_if_ready}, 32'h0);
    check("stall_resp_count", 32'(resp_count - r0), 32'h1);
    step();

    // Freeze during the MISS wait and again while the completion pulse is up.
    r0 = resp_count;
    f0 = fetch_count;
    e.pc = 32'h20;
    e.inst = mem_word(32'h20);
    sb.push_back(e);
    if_to_ic_pc = 32'h20;
    if_to_ic_valid = 1'b1;
    step();
    step();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_miss_req", {31'b0, ic_to_mc_ready}, 32'h1);
      check("stall_miss_pc", ic_to_mc_pc, 32'h20);
    end
    rdy_in = 1'b1;
    n = 0;
    while (!mc_to_ic_ready && n < 20) begin
      step();
      n++;
    end
    check("stall_ack_seen", {31'b0, mc_to_ic_ready}, 32'h1);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_ack_req", {31'b0, ic_to_mc_ready}, 32'h0);
      check("stall_ack_noresp", {31'b0, ic_to_if_ready}, 32'h0);
    end
    rdy_in = 1'b1;
    n = 0;
    while (resp_count == r0 && n < 5) begin
      step();
      n++;
    end
    if_to_ic_valid = 1'b0;
    check("stall_miss_resp", 32'(resp_count - r0), 32'h1);
    check("stall_miss_fetches", 32'(fetch_count - f0), 32'h1);
    step();

    // Controller busy with load/store traffic stretches the miss.
    mc_extra = 5;
    run_vec('{32'h0000_0024, -1, 1'b1, 1'b1});
    mc_extra = 0;

    // Asynchronous reset in the middle of a miss.
    if_to_ic_pc = 32'h28;
    if_to_ic_valid = 1'b1;
    step();
    step();
    step();
    check("pre_reset_req", {31'b0, ic_to_mc_ready}, 32'h1);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_mc_ready", {31'b0, ic_to_mc_ready}, 32'h0);
    check("async_rst_mc_pc", ic_to_mc_pc, 32'h0);
    check("async_rst_if_ready", {31'b0, ic_to_if_ready}, 32'h0);
    check("async_rst_if_inst", ic_to_if_inst, 32'h0);
    if_to_ic_valid = 1'b0;
    step();
    step();
    rst_in = 1'b0;
    step();
    run_vec('{32'h0000_0004, -1, 1'b1, 1'b1});
    run_vec('{32'h0000_0010, -1, 1'b1, 1'b1});
    run_vec('{32'h0000_0010, -1, 1'b0, 1'b1});

    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller. Serves fetch requests on a hit from its own arrays. On a miss it issues a single 32-bit fetch to the memory controller, fills the line, and forwards the word. A pipeline clear (`clr_in`) cancels delivery of an outstanding miss but never cancels the memory transaction.

## Interface
- `INDEX_WIDTH`, default 8: line index bits; 2^INDEX_WIDTH lines of 32 bits; tag = pc[31:INDEX_WIDTH+2].
- `clk_in`, input, 1: clock, rising edge.
- `rst_in`, input, 1: reset; asynchronous, active-high.
- `rdy_in`, input, 1: global enable; when low, all state freezes (reset still acts).
- `clr_in`, input, 1: pipeline flush.
- `if_to_ic_valid`, input, 1: fetch request; held high with stable pc until served.
- `if_to_ic_pc`, input, 32: fetch address, word-aligned.
- `ic_to_if_ready`, output, 1: one-cycle pulse; `ic_to_if_inst` valid.
- `ic_to_if_inst`, output, 32: fetched instruction.
- `ic_to_mc_ready`, output, 1: fetch request to memory controller (combinational, see Operation).
- `ic_to_mc_pc`, output, 32: registered miss address.
- `mc_to_ic_ready`, input, 1: memory controller completion pulse.
- `mc_dout`, input, 32: fetched word; valid only while `mc_to_ic_ready` is high.

## Operation
- Arrays: `valid[2^INDEX_WIDTH]`, `tag[]`, `data[]`. index = pc[INDEX_WIDTH+1:2].
- Hit = `valid[index]` && `tag[index]` == pc tag.
- Reset: all `valid` = 0; state IDLE; `drop` = 0; `ic_to_if_ready` = 0; `ic_to_if_inst` = 0; `ic_to_mc_pc` = 0. Tag and data arrays are not reset.
- `ic_to_mc_ready` = (state == MISS) && !`mc_to_ic_ready`. It is combinational so that it falls in the completion cycle. The controller re-samples in that same cycle, so a registered request would start a duplicate fetch.
- All register updates are gated by `rdy_in`.
- State IDLE (`ic_to_if_ready` = 0):
  - If `clr_in`: no action.
  - Else if `if_to_ic_valid` and hit: `ic_to_if_inst` <= `data[index]`, `ic_to_if_ready` <= 1, go to RESP.
  - Else if `if_to_ic_valid` and miss: `ic_to_mc_pc` <= pc, `drop` <= 0, go to MISS.
- State MISS:
  - `clr_in` sets `drop` <= 1. The request stays asserted, because the controller cannot abort.
  - On `mc_to_ic_ready`:
    - Always write `valid` = 1, `tag`, and `data` = `mc_dout` at the index of `ic_to_mc_pc`.
    - If !`drop` and !`clr_in`: `ic_to_if_inst` <= `mc_dout`, `ic_to_if_ready` <= 1, go to RESP.
    - Otherwise go to IDLE with no response.
  - `mc_dout` is captured only in the pulse cycle; the controller clears it afterward.
- State RESP: `ic_to_if_ready` <= 0, go to IDLE. Requests are ignored in this state, so the fetch unit has one cycle to advance pc. `clr_in` in RESP has no effect; the pulse already issued is not retracted.
- `clr_in` never invalidates cache contents.
- No writes from the load/store path; self-modifying code is unsupported.

## Timing
- Hit: request high in cycle 0 (IDLE) -> `ic_to_if_ready` high in cycle 1 -> IDLE in cycle 2. Peak throughput is 1 instruction per 2 cycles.
- Miss, with the load/store path idle:
  - cycle 1: MISS, `ic_to_mc_ready` = 1.
  - cycles 2-5: controller fetches 4 bytes.
  - cycle 6: `mc_to_ic_ready` = 1, `ic_to_mc_ready` = 0.
  - cycle 7: `ic_to_if_ready` = 1.
  - Load/store traffic has controller priority and extends the MISS wait by any amount.
- `ic_to_mc_pc` is stable for the whole MISS state.
- `ic_to_if_ready` is never high for more than one enabled cycle.
- `rdy_in` low: state, outputs and arrays hold. A `mc_to_ic_ready` seen while `rdy_in` is low is not consumed.
- Reset mid-miss returns to IDLE immediately with all lines invalid; no fill occurs.
- `clr_in` and `mc_to_ic_ready` in the same cycle: line filled, no response, next state IDLE.

## Test plan
- Cold miss, pc=0x0000_0004, controller returns 0x0040_0093 -> one `ic_to_mc_ready` episode, `ic_to_mc_pc`=0x4, `ic_to_if_inst`=0x0040_0093 one cycle after the `mc_to_ic_ready` pulse.
- Refetch pc=0x4 after the fill -> `ic_to_if_ready` one cycle after request; `ic_to_mc_ready` stays 0.
- Conflict, INDEX_WIDTH=8: fill pc=0x4, then fetch pc=0x404 (same index, different tag) -> miss and refill. pc=0x4 then misses again.
- `clr_in` pulsed two cycles into a miss on pc=0x8 -> fetch completes, no `ic_to_if_ready`, state IDLE. A later pc=0x8 fetch hits.
- Completion-cycle check -> `ic_to_mc_ready` is low in the `mc_to_ic_ready` cycle; the controller performs exactly one fetch per miss.
- `rdy_in` held low for 3 cycles during RESP and during MISS -> pulse width and state are held. Async `rst_in` mid-miss -> all outputs 0 without a clock edge, and pc=0x4 misses afterward.
